// File: rtl/crc_pkg.sv
// crc_pkg: shared state encoding, CRC-32 constants and byte-wise update
package crc_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, FCS = 2'd2, CHK = 2'd3} state_t;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam int FCS_BYTES = 4;
  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ CRC_POLY : r >> 1;
    return r;
  endfunction
endpackage

// File: rtl/crc32_frame_ctrl_fcs32.sv
// crc32_frame_ctrl_fcs32: byte-wise reflected CRC-32 engine with registered FCS capture
module crc32_frame_ctrl_fcs32
  import crc_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst_sys,
  input  logic [7:0]  din,
  input  logic        din_vld,
  input  logic        sop,
  input  logic        cap,
  output logic [31:0] dout
);
  logic [31:0] crc, nxt;
  assign nxt = crc_next(crc, din);
  // running CRC (sop wins over vld); capture folds in the current byte and inverts
  always_ff @(posedge clk_sys or posedge rst_sys)
    if (rst_sys) begin
      crc  <= CRC_INIT;
      dout <= '0;
    end else begin
      crc <= sop ? CRC_INIT : din_vld ? nxt : crc;
      if (cap) dout <= ~nxt;
    end
endmodule

// File: rtl/crc32_frame_ctrl.sv
// crc32_frame_ctrl: frame sequencer appending (TX) or checking (RX) the FCS32 on a byte stream
module crc32_frame_ctrl
  import crc_pkg::*;
#(
  parameter int MIN_RX_LEN = 5,
  parameter int CNT_W      = 16
) (
  input  logic       clk_sys,
  input  logic       rst_sys,
  input  logic       mode_tx,
  input  logic [7:0] in_data,
  input  logic       in_vld,
  input  logic       in_eop,
  output logic       in_rdy,
  output logic [7:0] out_data,
  output logic       out_vld,
  output logic       out_eop,
  input  logic       out_rdy,
  output logic       chk_ok,
  output logic       chk_err,
  output logic       busy
);
  state_t           state, state_n;
  logic             mode_q, m, pass, acc, held, last_fcs;
  logic             crc_sop, crc_din_vld, crc_cap;
  logic [7:0]       crc_din;
  logic [31:0]      crc_dout;
  logic [7:0]       sr [FCS_BYTES];
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;

  crc32_frame_ctrl_fcs32 u_fcs32 (
    .clk_sys (clk_sys),
    .rst_sys (rst_sys),
    .din     (crc_din),
    .din_vld (crc_din_vld),
    .sop     (crc_sop),
    .cap     (crc_cap),
    .dout    (crc_dout)
  );

  // handshake, datapath muxing, engine control and next state; in IDLE the live mode_tx applies
  always_comb begin
    pass        = state == IDLE || state == DATA;
    m           = state == IDLE ? mode_tx : mode_q;
    in_rdy      = pass & out_rdy & ~rst_sys;
    acc         = in_vld & in_rdy;
    held        = state == DATA && cnt >= CNT_W'(FCS_BYTES);
    last_fcs    = state == FCS && idx == 2'd3;
    out_vld     = ~rst_sys & (pass ? in_vld : state == FCS);
    out_data    = pass ? in_data : crc_dout[{idx, 3'b000} +: 8];
    out_eop     = ~rst_sys & (pass ? in_eop & ~m : last_fcs);
    chk_ok      = state == CHK && {sr[3], sr[2], sr[1], sr[0]} == crc_dout && cnt >= CNT_W'(MIN_RX_LEN);
    chk_err     = state == CHK && !chk_ok;
    busy        = state != IDLE;
    crc_sop     = (state == IDLE && !acc) || state == FCS || state == CHK;
    crc_din     = m ? in_data : sr[0];
    crc_din_vld = acc & (m | held);
    crc_cap     = acc & (m ? in_eop : held);
    state_n     = acc && in_eop ? (m ? FCS : CHK) :
                  acc && state == IDLE ? DATA :
                  (last_fcs && out_rdy) || state == CHK ? IDLE : state;
  end

  // state register
  always_ff @(posedge clk_sys or posedge rst_sys)
    if (rst_sys) state <= IDLE;
    else state <= state_n;

  // frame mode, saturating byte count, FCS byte index and RX delay line
  always_ff @(posedge clk_sys or posedge rst_sys)
    if (rst_sys) begin
      mode_q <= 1'b0;
      cnt    <= '0;
      idx    <= '0;
      for (int i = 0; i < FCS_BYTES; i++) sr[i] <= '0;
    end else begin
      mode_q <= state == IDLE && acc ? mode_tx : mode_q;
      cnt    <= state == IDLE ? CNT_W'(acc) : acc && !(&cnt) ? cnt + 1'b1 : cnt;
      idx    <= state == FCS ? idx + 2'(out_rdy) : 2'd0;
      if (acc && !m) begin
        for (int i = 0; i < FCS_BYTES - 1; i++) sr[i] <= sr[i+1];
        sr[FCS_BYTES-1] <= in_data;
      end
    end
endmodule

// File: tb/tb_crc32_frame_ctrl.sv
// tb_crc32_frame_ctrl: scoreboard bench with directed TX/RX frames
module tb_crc32_frame_ctrl;
  logic       clk_sys = 1'b0;
  logic       rst_sys = 1'b1;
  logic       mode_tx = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_vld = 1'b0;
  logic       in_eop = 1'b0;
  logic       in_rdy;
  logic [7:0] out_data;
  logic       out_vld;
  logic       out_eop;
  logic       out_rdy = 1'b1;
  logic       chk_ok;
  logic       chk_err;
  logic       busy;
  logic       tog = 1'b0;

  logic [8:0] exp_q[$];
  logic       exp_st[$];
  int         checks = 0;
  int         errors = 0;
  int         probe_req = 0;
  int         probe_done = 0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_d = '0;

  crc32_frame_ctrl #(.MIN_RX_LEN(5), .CNT_W(16)) dut (
    .clk_sys  (clk_sys),
    .rst_sys  (rst_sys),
    .mode_tx  (mode_tx),
    .in_data  (in_data),
    .in_vld   (in_vld),
    .in_eop   (in_eop),
    .in_rdy   (in_rdy),
    .out_data (out_data),
    .out_vld  (out_vld),
    .out_eop  (out_eop),
    .out_rdy  (out_rdy),
    .chk_ok   (chk_ok),
    .chk_err  (chk_err),
    .busy     (busy)
  );

  always #5 clk_sys = ~clk_sys;

  always begin
    @(posedge clk_sys);
    #1;
    out_rdy = tog ? ~out_rdy : 1'b1;
  end

  task automatic ck(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  always @(negedge clk_sys) begin
    if (hold_pend) ck("stall_hold", {out_vld, out_data}, {1'b1, hold_d});
    hold_pend = out_vld && !out_rdy && busy && !in_rdy && !rst_sys;
    hold_d = out_data;
    if (out_vld && out_rdy) begin
      if (exp_q.size() == 0) ck("unexpected_out", {out_eop, out_data}, 9'h000 - 1'b1);
      else ck("out_byte", {out_eop, out_data}, exp_q.pop_front());
    end
    if (chk_ok || chk_err) begin
      if (exp_st.size() == 0) ck("unexpected_status", {chk_ok, chk_err}, 2'b00);
      else begin
        logic e;
        e = exp_st.pop_front();
        ck("status", {chk_ok, chk_err}, {e, ~e});
      end
    end
    if (probe_req != probe_done) begin
      probe_done++;
      ck("idle_busy", busy, 0);
      ck("idle_out", {out_vld, out_eop, chk_ok, chk_err}, 0);
      ck("idle_rdy", in_rdy, !rst_sys && out_rdy);
      ck("queues_empty", exp_q.size() + exp_st.size(), 0);
    end
  end

  task automatic drive(input logic [7:0] d, input logic eop, input logic mode);
    logic ok;
    in_data = d;
    in_eop  = eop;
    mode_tx = mode;
    in_vld  = 1'b1;
    for (int t = 0; t <= 200; t++) begin
      if (t == 200) begin
        $display("FAIL accept_timeout: got no in_rdy expected accept of %0h", d);
        $fatal(1);
      end
      @(negedge clk_sys);
      ok = in_rdy;
      @(posedge clk_sys);
      #1;
      if (ok) break;
    end
    in_vld = 1'b0;
    in_eop = 1'b0;
  endtask

  task automatic send(input logic mode, input logic [7:0] b[$], input logic [31:0] fcs, input logic st);
    for (int i = 0; i < b.size(); i++) begin
      logic last;
      last = i == b.size() - 1;
      exp_q.push_back({!mode && last, b[i]});
      if (!mode && last) exp_st.push_back(st);
      drive(b[i], last, i == 0 ? mode : ~mode);
    end
    if (mode)
      for (int k = 0; k < 4; k++) exp_q.push_back({k == 3, fcs[8*k +: 8]});
  endtask

  task automatic settle();
    for (int t = 0; t < 300 && (exp_q.size() != 0 || exp_st.size() != 0); t++) @(posedge clk_sys);
    repeat (3) @(posedge clk_sys);
    #1;
    probe_req++;
    repeat (2) @(posedge clk_sys);
    #1;
  endtask

  initial begin
    logic [7:0] f9[$], rx13[$], rxbad[$], rx4[$], one[$], part[$];
    f9    = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    rx13  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
    rxbad = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCA};
    rx4   = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    one   = '{8'h00};
    part  = '{8'h31, 8'h32, 8'h33};
    repeat (3) @(posedge clk_sys);
    #1;
    probe_req++;
    repeat (2) @(posedge clk_sys);
    #1;
    rst_sys = 1'b0;
    send(1'b1, f9, 32'hCBF43926, 1'b0);
    settle();
    send(1'b0, rx13, 32'h0, 1'b1);
    settle();
    send(1'b0, rxbad, 32'h0, 1'b0);
    settle();
    send(1'b0, rx4, 32'h0, 1'b0);
    settle();
    tog = 1'b1;
    send(1'b1, one, 32'hD202EF8D, 1'b0);
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk_sys);
    tog = 1'b0;
    settle();
    for (int i = 0; i < part.size(); i++) begin
      exp_q.push_back({1'b0, part[i]});
      drive(part[i], 1'b0, 1'b1);
    end
    rst_sys = 1'b1;
    @(posedge clk_sys);
    #1;
    rst_sys = 1'b0;
    settle();
    send(1'b1, f9, 32'hCBF43926, 1'b0);
    settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/crc32_frame_ctrl.md
Name: crc32_frame_ctrl

Overview:
Frame-level sequencer for the byte-wise FCS32 CRC-32 engine. It sits on the 8-bit frame stream between the framer and the link serialiser. In TX mode it feeds payload bytes to the engine and appends the 4-byte FCS. In RX mode it feeds all bytes except the trailing 4, compares the trailing 4 bytes against the computed FCS, and reports a one-cycle pass/fail pulse per frame. Both directions use a valid/ready byte stream.

Parameters:
MIN_RX_LEN, 5, minimum RX frame length in bytes, FCS included; shorter frames fail.
CNT_W, 16, width of the per-frame byte counter; the counter saturates.

Ports:
clk_sys  in  1  system clock
rst_sys  in  1  asynchronous reset, active-high
mode_tx  in  1  1 = generate/append FCS, 0 = check FCS; sampled on the first byte of each frame
in_data  in  8  input frame byte
in_vld  in  1  input byte valid
in_eop  in  1  last byte of the input frame, qualified by in_vld
in_rdy  out  1  input byte accepted when in_vld & in_rdy
out_data  out  8  output frame byte
out_vld  out  1  output byte valid
out_eop  out  1  last byte of the output frame
out_rdy  in  1  downstream ready
chk_ok  out  1  1-cycle pulse: RX frame FCS matched
chk_err  out  1  1-cycle pulse: RX FCS mismatch or frame shorter than MIN_RX_LEN
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset: state IDLE, shift register and counter cleared, chk_ok = chk_err = 0, out_vld = 0, out_eop = 0, in_rdy = 0.
- States: IDLE, DATA, FCS, CHK.
- IDLE:
  - Engine crc_sop = 1 every cycle in which no byte is accepted, so the engine holds all-ones before the first byte.
  - in_rdy = out_rdy. A byte accept latches mode_tx as frame mode and goes to DATA, or to FCS/CHK if that byte also carries in_eop.
  - On the first byte, crc_sop = 0 and crc_din_vld = 1 (engine sop has priority over vld).
- DATA: pass-through. out_data = in_data, out_vld = in_vld, in_rdy = out_rdy. accept = in_vld & out_rdy.
- TX mode:
  - crc_din_vld = accept; crc_cap = accept & in_eop. Input eop is never forwarded.
  - On the eop accept, go to FCS with byte index 0.
- FCS (TX only):
  - in_rdy = 0, out_vld = 1.
  - out_data = crc_dout[7:0], [15:8], [23:16], [31:24] for index 0..3; the index advances only on out_rdy.
  - out_eop = 1 at index 3; on that handshake go to IDLE.
  - crc_dout is valid in the first FCS cycle because of the 1-cycle capture latency.
- RX mode:
  - A 4-byte shift register holds the last 4 accepted bytes. Once 4 bytes are held, each accept pushes the oldest byte into the engine: crc_din_vld = crc_cap = 1, crc_din = oldest byte.
  - The engine capture therefore always reflects the CRC up to 4 bytes before the current byte.
  - out_eop = in_eop; all bytes are forwarded unchanged. On the eop accept, go to CHK.
- CHK (RX only, 1 cycle):
  - in_rdy = 0.
  - Compare {byte0..byte3} (byte0 = oldest) with crc_dout[7:0]..[31:24].
  - Pulse chk_ok on match with count ≥ MIN_RX_LEN, otherwise pulse chk_err. Then go to IDLE.
- Counter: counts accepted bytes, saturates at 2^CNT_W − 1, clears in IDLE.
- Input bytes with in_vld low: no engine activity, state held.
- out_rdy low in FCS: the current byte is held stable; there is no timeout.
- Async reset mid-frame: immediate return to IDLE. The partial frame is dropped with no status pulse and no out_eop.
- mode_tx changes mid-frame: ignored until the next first-byte accept.

Decomposition:
- Shared package crc_pkg: state encoding (IDLE = 0, DATA = 1, FCS = 2, CHK = 3), CRC_INIT = 32'hFFFFFFFF, FCS_BYTES = 4.
- One sub-module: the existing FCS32 engine, instantiated once and driven by crc_din, crc_din_vld, crc_sop and crc_cap from this block.
- The 4-byte delay line stays inline.

Test Plan:
- TX "123456789" (9 bytes), out_rdy = 1 → output 31..39 then 26 39 F4 CB, out_eop on CB; 13 output bytes total; busy low afterwards.
- RX 31..39,26,39,F4,CB → chk_ok pulse 1 cycle after the eop accept, chk_err = 0, all 13 bytes forwarded.
- RX same frame with last byte CA → chk_err pulse, chk_ok = 0.
- RX 4-byte frame 26 39 F4 CB → chk_err (length < MIN_RX_LEN).
- TX 1-byte frame 00 with out_rdy toggled 1/0 every cycle in FCS → FCS bytes held stable while stalled, sequence 8D EF 02 D2 (CRC 0xD202EF8D), no lost or duplicated bytes.
- Assert rst_sys for 1 cycle mid-DATA, then send TX "123456789" → no status or eop from the aborted frame; the new frame FCS equals 26 39 F4 CB.
